// File: rtl/mem_access_pkg.sv
// rtl/mem_access_pkg.sv - shared constants and types for the RV32 load/store stage
package mem_access_pkg;

    localparam logic [2:0] FUNCT3_B  = 3'b000;
    localparam logic [2:0] FUNCT3_H  = 3'b001;
    localparam logic [2:0] FUNCT3_W  = 3'b010;
    localparam logic [2:0] FUNCT3_BU = 3'b100;
    localparam logic [2:0] FUNCT3_HU = 3'b101;

    localparam logic [1:0] FAULT_NONE       = 2'd0;
    localparam logic [1:0] FAULT_MISALIGNED = 2'd1;
    localparam logic [1:0] FAULT_TIMEOUT    = 2'd2;
    localparam logic [1:0] FAULT_ILLEGAL    = 2'd3;

    typedef enum logic {
        S_IDLE,
        S_BUS
    } state_t;

endpackage

// File: rtl/mem_align_unit.sv
// rtl/mem_align_unit.sv - store lane steering, load extraction/extension and access legality checks
module mem_align_unit
    import mem_access_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  lane,
    input  logic        is_read,
    input  logic        is_write,
    input  logic [31:0] store_data,
    input  logic [31:0] load_data,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic [31:0] load_ext,
    output logic        misaligned,
    output logic        illegal
);

    logic [31:0] shifted;

    // Replicate store data across lanes so the slave can pick any byte/half; strobes select the lane.
    always_comb begin
        wdata = store_data;
        wstrb = 4'b1111;
        case (funct3[1:0])
            2'b00: begin
                wdata = {4{store_data[7:0]}};
                wstrb = 4'b0001 << lane;
            end
            2'b01: begin
                wdata = {2{store_data[15:0]}};
                wstrb = 4'b0011 << lane;
            end
            default: wstrb = 4'b1111;
        endcase
        if (!is_write) begin
            wstrb = 4'b0000;
        end
    end

    assign shifted = load_data >> {lane, 3'b000};

    // Bring the addressed byte/half down to bit 0 and sign- or zero-extend it.
    always_comb begin
        load_ext = shifted;
        case (funct3)
            FUNCT3_B:  load_ext = {{24{shifted[7]}}, shifted[7:0]};
            FUNCT3_H:  load_ext = {{16{shifted[15]}}, shifted[15:0]};
            FUNCT3_BU: load_ext = {24'h000000, shifted[7:0]};
            FUNCT3_HU: load_ext = {16'h0000, shifted[15:0]};
            default:   load_ext = shifted;
        endcase
    end

    // Unsigned widths have no store form, and 011/11x are not RV32 load/store encodings.
    always_comb begin
        illegal    = (is_read & is_write) | (funct3 == 3'b011) | (funct3[2:1] == 2'b11)
                   | (is_write & funct3[2]);
        misaligned = ((funct3[1:0] == 2'b01) & lane[0])
                   | ((funct3[1:0] == 2'b10) & (lane != 2'b00));
    end

endmodule

// File: rtl/memory_access.sv
// rtl/memory_access.sv - RV32 load/store stage: one bus transaction per memory op with stall and faults
module memory_access
    import mem_access_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int BUS_TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ex_valid,
    input  logic            memory_read_enable,
    input  logic            memory_write_enable,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] alu_result,
    input  logic [XLEN-1:0] reg2_data,
    output logic            bus_req,
    output logic            bus_we,
    output logic [XLEN-1:0] bus_addr,
    output logic [XLEN-1:0] bus_wdata,
    output logic [3:0]      bus_wstrb,
    input  logic [XLEN-1:0] bus_rdata,
    input  logic            bus_ack,
    output logic            mem_stall,
    output logic [XLEN-1:0] memory_read_data,
    output logic            mem_done,
    output logic            mem_fault,
    output logic [1:0]      fault_cause
);

    localparam int CW = $clog2(BUS_TIMEOUT);

    state_t          state;
    logic [2:0]      lat_funct3;
    logic [1:0]      lat_lane;
    logic [CW-1:0]   wait_cnt;

    logic [2:0]      sel_funct3;
    logic [1:0]      sel_lane;
    logic            sel_read;
    logic            sel_write;
    logic [XLEN-1:0] al_wdata;
    logic [3:0]      al_wstrb;
    logic [XLEN-1:0] al_load;
    logic            al_misaligned;
    logic            al_illegal;
    logic            accept;
    logic            accept_ok;

    // One align unit serves both phases: live instruction fields in IDLE, latched ones during BUS.
    always_comb begin
        sel_funct3 = (state == S_BUS) ? lat_funct3 : funct3;
        sel_lane   = (state == S_BUS) ? lat_lane : alu_result[1:0];
        sel_read   = (state == S_BUS) ? ~bus_we : memory_read_enable;
        sel_write  = (state == S_BUS) ? bus_we : memory_write_enable;
    end

    mem_align_unit u_align (
        .funct3     (sel_funct3),
        .lane       (sel_lane),
        .is_read    (sel_read),
        .is_write   (sel_write),
        .store_data (reg2_data),
        .load_data  (bus_rdata),
        .wdata      (al_wdata),
        .wstrb      (al_wstrb),
        .load_ext   (al_load),
        .misaligned (al_misaligned),
        .illegal    (al_illegal)
    );

    assign accept    = (state == S_IDLE) & ex_valid & (memory_read_enable | memory_write_enable);
    assign accept_ok = accept & ~al_illegal & ~al_misaligned;
    assign mem_stall = ~rst & (accept_ok | (state == S_BUS));

    // Transaction FSM: accept/check in IDLE, hold the request in BUS until ack or timeout.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= S_IDLE;
            lat_funct3       <= 3'b000;
            lat_lane         <= 2'b00;
            wait_cnt         <= '0;
            bus_req          <= 1'b0;
            bus_we           <= 1'b0;
            bus_addr         <= '0;
            bus_wdata        <= '0;
            bus_wstrb        <= 4'b0000;
            memory_read_data <= '0;
            mem_done         <= 1'b0;
            mem_fault        <= 1'b0;
            fault_cause      <= FAULT_NONE;
        end else begin
            mem_done    <= 1'b0;
            mem_fault   <= 1'b0;
            fault_cause <= FAULT_NONE;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        if (al_illegal) begin
                            mem_fault   <= 1'b1;
                            fault_cause <= FAULT_ILLEGAL;
                        end else if (al_misaligned) begin
                            mem_fault   <= 1'b1;
                            fault_cause <= FAULT_MISALIGNED;
                        end else begin
                            state      <= S_BUS;
                            lat_funct3 <= funct3;
                            lat_lane   <= alu_result[1:0];
                            wait_cnt   <= '0;
                            bus_req    <= 1'b1;
                            bus_we     <= memory_write_enable;
                            bus_addr   <= {alu_result[XLEN-1:2], 2'b00};
                            bus_wdata  <= al_wdata;
                            bus_wstrb  <= al_wstrb;
                        end
                    end
                end
                S_BUS: begin
                    if (bus_ack) begin
                        if (!bus_we) begin
                            memory_read_data <= al_load;
                        end
                        mem_done  <= 1'b1;
                        bus_req   <= 1'b0;
                        bus_we    <= 1'b0;
                        bus_wstrb <= 4'b0000;
                        state     <= S_IDLE;
                    end else if (wait_cnt == CW'(BUS_TIMEOUT - 1)) begin
                        mem_fault   <= 1'b1;
                        fault_cause <= FAULT_TIMEOUT;
                        bus_req     <= 1'b0;
                        bus_we      <= 1'b0;
                        bus_wstrb   <= 4'b0000;
                        state       <= S_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_memory_access.sv
// tb/tb_memory_access.sv - scoreboard bench for memory_access
module tb_memory_access;

    typedef struct {
        logic        fault;
        logic [1:0]  cause;
        logic [31:0] data;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        ex_valid;
    logic        memory_read_enable;
    logic        memory_write_enable;
    logic [2:0]  funct3;
    logic [31:0] alu_result;
    logic [31:0] reg2_data;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_rdata;
    logic        bus_ack;
    logic        mem_stall;
    logic [31:0] memory_read_data;
    logic        mem_done;
    logic        mem_fault;
    logic [1:0]  fault_cause;

    int   n_cmp = 0;
    int   n_err = 0;
    exp_t sb[$];
    logic [31:0] last_rd;

    memory_access #(.XLEN(32), .BUS_TIMEOUT(16)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .ex_valid            (ex_valid),
        .memory_read_enable  (memory_read_enable),
        .memory_write_enable (memory_write_enable),
        .funct3              (funct3),
        .alu_result          (alu_result),
        .reg2_data           (reg2_data),
        .bus_req             (bus_req),
        .bus_we              (bus_we),
        .bus_addr            (bus_addr),
        .bus_wdata           (bus_wdata),
        .bus_wstrb           (bus_wstrb),
        .bus_rdata           (bus_rdata),
        .bus_ack             (bus_ack),
        .mem_stall           (mem_stall),
        .memory_read_data    (memory_read_data),
        .mem_done            (mem_done),
        .mem_fault           (mem_fault),
        .fault_cause         (fault_cause)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Completion monitor: every done/fault pulse must match the oldest scoreboard entry.
    always @(negedge clk) begin
        if (!rst && (mem_done || mem_fault)) begin
            if (sb.size() == 0) begin
                check("unexpected_completion", {30'd0, mem_fault, mem_done}, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (e.fault) begin
                    check("fault_pulse", {31'd0, mem_fault}, 32'd1);
                    check("fault_cause", {30'd0, fault_cause}, {30'd0, e.cause});
                    check("fault_no_done", {31'd0, mem_done}, 32'd0);
                end else begin
                    check("done_pulse", {31'd0, mem_done}, 32'd1);
                    check("read_data", memory_read_data, e.data);
                    check("done_no_fault", {31'd0, mem_fault}, 32'd0);
                end
            end
        end
    end

    task automatic drive(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd);
        ex_valid            = 1'b1;
        memory_read_enable  = rd;
        memory_write_enable = wr;
        funct3              = f3;
        alu_result          = addr;
        reg2_data           = wd;
    endtask

    task automatic idle_inputs();
        ex_valid            = 1'b0;
        memory_read_enable  = 1'b0;
        memory_write_enable = 1'b0;
        funct3              = 3'b000;
        alu_result          = 32'd0;
        reg2_data           = 32'd0;
    endtask

    task automatic run_op(input string tag, input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd, input int waits,
                          input logic [31:0] rdata, input logic [31:0] exp_data,
                          input logic [31:0] exp_addr, input logic [31:0] exp_wdata,
                          input logic [3:0] exp_wstrb);
        exp_t e;
        e.fault = 1'b0;
        e.cause = 2'd0;
        e.data  = exp_data;
        sb.push_back(e);
        @(negedge clk);
        drive(rd, wr, f3, addr, wd);
        #1;
        check({tag, "_stall_accept"}, {31'd0, mem_stall}, 32'd1);
        @(negedge clk);
        idle_inputs();
        check({tag, "_req"}, {31'd0, bus_req}, 32'd1);
        check({tag, "_addr"}, bus_addr, exp_addr);
        check({tag, "_we"}, {31'd0, bus_we}, {31'd0, wr});
        check({tag, "_wdata"}, bus_wdata, exp_wdata);
        check({tag, "_wstrb"}, {28'd0, bus_wstrb}, {28'd0, exp_wstrb});
        repeat (waits) @(negedge clk);
        check({tag, "_req_held"}, {31'd0, bus_req}, 32'd1);
        check({tag, "_stall_bus"}, {31'd0, mem_stall}, 32'd1);
        bus_ack   = 1'b1;
        bus_rdata = rdata;
        @(negedge clk);
        bus_ack   = 1'b0;
        bus_rdata = 32'd0;
        check({tag, "_req_drop"}, {31'd0, bus_req}, 32'd1 ^ 32'd1);
        @(negedge clk);
        check({tag, "_done_single"}, {31'd0, mem_done}, 32'd0);
        last_rd = exp_data;
    endtask

    task automatic run_fault(input string tag, input logic rd, input logic wr, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [1:0] cause);
        exp_t e;
        e.fault = 1'b1;
        e.cause = cause;
        e.data  = 32'd0;
        sb.push_back(e);
        @(negedge clk);
        drive(rd, wr, f3, addr, 32'h5A5A5A5A);
        #1;
        check({tag, "_no_stall"}, {31'd0, mem_stall}, 32'd0);
        @(negedge clk);
        idle_inputs();
        check({tag, "_no_req"}, {31'd0, bus_req}, 32'd0);
        check({tag, "_stall_after"}, {31'd0, mem_stall}, 32'd0);
        @(negedge clk);
        check({tag, "_fault_single"}, {31'd0, mem_fault}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        exp_t e;
        idle_inputs();
        bus_ack   = 1'b0;
        bus_rdata = 32'd0;
        last_rd   = 32'd0;
        rst       = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_req", {31'd0, bus_req}, 32'd0);
        check("rst_rdata", memory_read_data, 32'd0);
        check("rst_flags", {28'd0, mem_done, mem_fault, fault_cause}, 32'd0);
        check("rst_stall", {31'd0, mem_stall}, 32'd0);
        rst = 1'b0;

        run_op("lw", 1, 0, 3'b010, 32'h100, 0, 1, 32'hDEADBEEF, 32'hDEADBEEF, 32'h100, 32'h0, 4'b0000);
        run_op("lb", 1, 0, 3'b000, 32'h103, 0, 0, 32'h80AA5511, 32'hFFFFFF80, 32'h100, 32'h0, 4'b0000);
        run_op("lbu", 1, 0, 3'b100, 32'h103, 0, 2, 32'h80AA5511, 32'h00000080, 32'h100, 32'h0, 4'b0000);
        run_op("lhu", 1, 0, 3'b101, 32'h102, 0, 0, 32'h80AA5511, 32'h000080AA, 32'h100, 32'h0, 4'b0000);
        run_op("lh", 1, 0, 3'b001, 32'h102, 0, 1, 32'h80AA5511, 32'hFFFF80AA, 32'h100, 32'h0, 4'b0000);
        run_op("lh_lo", 1, 0, 3'b001, 32'h300, 0, 0, 32'h12347FFE, 32'h00007FFE, 32'h300, 32'h0, 4'b0000);
        run_op("sb", 0, 1, 3'b000, 32'h201, 32'h123456AB, 1, 32'hFFFFFFFF, last_rd, 32'h200, 32'hABABABAB, 4'b0010);
        run_op("sh", 0, 1, 3'b001, 32'h202, 32'h0000BEEF, 0, 32'h0, last_rd, 32'h200, 32'hBEEFBEEF, 4'b1100);
        run_op("sw", 0, 1, 3'b010, 32'h204, 32'hCAFEF00D, 0, 32'h0, last_rd, 32'h204, 32'hCAFEF00D, 4'b1111);

        run_fault("mis_lw", 1, 0, 3'b010, 32'h102, 2'd1);
        run_fault("mis_lh", 1, 0, 3'b001, 32'h101, 2'd1);
        run_fault("mis_lhu", 1, 0, 3'b101, 32'h103, 2'd1);
        run_fault("mis_sw", 0, 1, 3'b010, 32'h203, 2'd1);
        run_fault("ill_sbu", 0, 1, 3'b100, 32'h200, 2'd3);
        run_fault("ill_rw", 1, 1, 3'b010, 32'h200, 2'd3);
        run_fault("ill_f011", 1, 0, 3'b011, 32'h200, 2'd3);
        run_fault("ill_f110", 1, 0, 3'b110, 32'h200, 2'd3);
        run_fault("ill_shu_mis", 0, 1, 3'b101, 32'h201, 2'd3);
        check("rdata_kept_after_faults", memory_read_data, last_rd);

        @(negedge clk);
        ex_valid = 1'b1;
        #1;
        check("nop_no_stall", {31'd0, mem_stall}, 32'd0);
        @(negedge clk);
        idle_inputs();
        check("nop_no_req", {31'd0, bus_req}, 32'd0);

        e.fault = 1'b1;
        e.cause = 2'd2;
        e.data  = 32'd0;
        sb.push_back(e);
        @(negedge clk);
        drive(1, 0, 3'b010, 32'h400, 0);
        @(negedge clk);
        idle_inputs();
        n = 0;
        while (bus_req && n < 100) begin
            n++;
            @(negedge clk);
        end
        check("timeout_req_cycles", n, 32'd16);
        check("timeout_req_low", {31'd0, bus_req}, 32'd0);
        bus_ack   = 1'b1;
        bus_rdata = 32'h77777777;
        repeat (2) @(negedge clk);
        bus_ack   = 1'b0;
        bus_rdata = 32'd0;
        check("late_ack_ignored_req", {31'd0, bus_req}, 32'd0);
        check("late_ack_ignored_data", memory_read_data, last_rd);
        run_op("lw_after_to", 1, 0, 3'b010, 32'h404, 0, 0, 32'h0BADF00D, 32'h0BADF00D, 32'h404, 32'h0, 4'b0000);

        @(negedge clk);
        drive(1, 0, 3'b010, 32'h500, 0);
        @(negedge clk);
        idle_inputs();
        check("pre_rst_req", {31'd0, bus_req}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_req", {31'd0, bus_req}, 32'd0);
        check("mid_rst_stall", {31'd0, mem_stall}, 32'd0);
        check("mid_rst_rdata", memory_read_data, 32'd0);
        check("mid_rst_addr", bus_addr, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_op("lw_after_rst", 1, 0, 3'b010, 32'h508, 0, 1, 32'h13579BDF, 32'h13579BDF, 32'h508, 32'h0, 4'b0000);

        repeat (2) @(negedge clk);
        check("scoreboard_empty", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
